// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu shared package: size codes, FSM encoding, lane helpers.
// Optional RISCV_LSU_MISALIGN_CHECK_EN adds the alignment predicate.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] lsu_be(
    input logic [2:0] size,
    input logic [1:0] off
  );
    case (size)
      LDST_B, LDST_BU: lsu_be = 4'b0001 << off;
      LDST_H, LDST_HU: lsu_be = 4'b0011 << {off[1], 1'b0};
      default:         lsu_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wd(
    input logic [2:0]  size,
    input logic [31:0] wd
  );
    case (size)
      LDST_B, LDST_BU: lsu_wd = {4{wd[7:0]}};
      LDST_H, LDST_HU: lsu_wd = {2{wd[15:0]}};
      default:         lsu_wd = wd;
    endcase
  endfunction

`ifdef RISCV_LSU_MISALIGN_CHECK_EN
  function automatic logic lsu_misaligned(
    input logic [2:0] size,
    input logic [1:0] off
  );
    case (size)
      LDST_B, LDST_BU: lsu_misaligned = 1'b0;
      LDST_H, LDST_HU: lsu_misaligned = off[0];
      default:         lsu_misaligned = |off;
    endcase
  endfunction
`endif

endpackage

// File: rtl/riscv_lsu_extend.sv
// riscv_lsu_extend: selects the addressed lane of a read word
// and sign- or zero-extends it to 32 bits.
module riscv_lsu_extend
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = rdata_i[{off_i, 3'b000} +: 8];
  assign half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    case (size_i)
      LDST_B:  data_o = {{24{byte_w[7]}}, byte_w};
      LDST_BU: data_o = {24'b0, byte_w};
      LDST_H:  data_o = {{16{half_w[15]}}, half_w};
      LDST_HU: data_o = {16'b0, half_w};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit with registered memory handshake.
// Define RISCV_LSU_MISALIGN_CHECK_EN to trap misaligned accesses.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  input  logic              mem_ready_i
);

  lsu_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] rd_q;
  logic [1:0]        off_q;
  logic [2:0]        size_q;
  logic [31:0]       ext;

  riscv_lsu_extend u_ext (
    .rdata_i (mem_rd_i),
    .off_i   (off_q),
    .size_i  (size_q),
    .data_o  (ext)
  );

`ifdef RISCV_LSU_MISALIGN_CHECK_EN
  logic mis_q;
  assign misalign_o = mis_q;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      off_q   <= '0;
      size_q  <= '0;
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
      unique case (state_q)
        LSU_IDLE: begin
          if (core_req_i) begin
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
            if (lsu_misaligned(core_size_i, core_addr_i[1:0])) begin
              mis_q   <= 1'b1;
              rd_q    <= '0;
              state_q <= LSU_RESP;
            end else
`endif
            begin
              req_q   <= 1'b1;
              we_q    <= core_we_i;
              be_q    <= lsu_be(core_size_i, core_addr_i[1:0]);
              addr_q  <= {core_addr_i[ADDR_W-1:2], 2'b00};
              wd_q    <= lsu_wd(core_size_i, core_wd_i);
              off_q   <= core_addr_i[1:0];
              size_q  <= core_size_i;
              state_q <= LSU_BUSY;
            end
          end
        end
        LSU_BUSY: begin
          if (mem_ready_i) begin
            req_q <= 1'b0;
            if (!we_q) rd_q <= ext;
            state_q <= LSU_RESP;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  // Stall is gated by reset so every output reads 0 while held.
  always_comb begin
    case (state_q)
      LSU_IDLE: core_stall_o = core_req_i & arstn_i;
      LSU_BUSY: core_stall_o = arstn_i;
      default:  core_stall_o = 1'b0;
    endcase
  end

  assign mem_req_o  = req_q;
  assign mem_we_o   = we_q;
  assign mem_be_o   = be_q;
  assign mem_addr_o = addr_q;
  assign mem_wd_o   = wd_q;
  assign core_rd_o  = rd_q;

endmodule
